// File: rtl/game_input_ctrl.sv
// Gamepad front end: synchronises and debounces the start/reset buttons into
// one-cycle request pulses and runs the round countdown timer.
module game_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TICK_CYCLES     = 100_000_000,
    parameter int unsigned GAME_SECONDS    = 60
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn_start,
    input  logic       btn_reset,
    input  logic [1:0] current_state,
    output logic       start_game,
    output logic       reset_game,
    output logic       end_game,
    output logic [6:0] time_left
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned PS_W = $clog2(TICK_CYCLES);
    localparam int unsigned TL_W = 7;

    localparam logic [1:0] START_STATE = 2'd0;
    localparam logic [1:0] PLAY_STATE  = 2'd1;

    localparam int unsigned BTN_START = 0;
    localparam int unsigned BTN_RESET = 1;

    logic [1:0]      btn_raw;
    logic [1:0]      s1;
    logic [1:0]      s2;
    logic [1:0]      db;
    logic [1:0]      db_d;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      press;

    logic [1:0]      prev_state;
    logic [PS_W-1:0] prescaler;
    logic            play_entry;
    logic            in_play;

    assign btn_raw = {btn_reset, btn_start};
    assign press   = db & ~db_d;

    // Synchroniser and debounce: db follows s2 only after it has differed for DEBOUNCE_CYCLES edges
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_d <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            s1   <= btn_raw;
            s2   <= s1;
            db_d <= db;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]     <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Reset request wins over a simultaneous start; start is dropped during play
    always_ff @(posedge CLK) begin
        if (RST) begin
            start_game <= 1'b0;
            reset_game <= 1'b0;
        end else begin
            reset_game <= press[BTN_RESET];
            start_game <= press[BTN_START] & ~press[BTN_RESET] &
                          (current_state != PLAY_STATE);
        end
    end

    assign in_play    = (current_state == PLAY_STATE);
    assign play_entry = in_play && (prev_state != PLAY_STATE);

    // Round timer: reload on play entry, count down once per TICK_CYCLES while playing
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_state <= START_STATE;
            prescaler  <= '0;
            time_left  <= TL_W'(GAME_SECONDS);
            end_game   <= 1'b0;
        end else begin
            prev_state <= current_state;
            end_game   <= 1'b0;
            if (play_entry) begin
                time_left <= TL_W'(GAME_SECONDS);
                prescaler <= '0;
            end else if (in_play) begin
                if (prescaler == PS_W'(TICK_CYCLES - 1)) begin
                    prescaler <= '0;
                    if (time_left != '0) begin
                        time_left <= time_left - TL_W'(1);
                        if (time_left == TL_W'(1)) begin
                            end_game <= 1'b1;
                        end
                    end
                end else begin
                    prescaler <= prescaler + PS_W'(1);
                end
            end else begin
                prescaler <= '0;
                if (current_state == START_STATE) begin
                    time_left <= TL_W'(GAME_SECONDS);
                end
            end
        end
    end

endmodule

// File: tb/tb_game_input_ctrl.sv
// Randomised scoreboard bench for game_input_ctrl: a level/run-length model
// predicts every pulse and time_left change; a monitor pops and compares.
module tb_game_input_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned T = 10;
    localparam int unsigned G = 3;

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_END   = 2'd2;

    localparam int K_START = 0;
    localparam int K_RESET = 1;
    localparam int K_END   = 2;
    localparam int K_TL    = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_reset = 1'b0;
    logic [1:0] current_state = ST_START;
    logic       start_game;
    logic       reset_game;
    logic       end_game;
    logic [6:0] time_left;

    game_input_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .TICK_CYCLES    (T),
        .GAME_SECONDS   (G)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .btn_start    (btn_start),
        .btn_reset    (btn_reset),
        .current_state(current_state),
        .start_game   (start_game),
        .reset_game   (reset_game),
        .end_game     (end_game),
        .time_left    (time_left)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t evq [4][$];
    int  cyc    = 0;
    int  errors = 0;
    int  checks = 0;
    logic [6:0] last_tl = 7'(G);

    // Reference model state
    bit [1:0] m_s1  = '0;
    bit [1:0] m_s2  = '0;
    bit [1:0] m_db  = '0;
    bit [1:0] m_lvl = '0;
    bit [1:0] m_rose = '0;
    int       m_run [2] = '{0, 0};
    int       m_n  = 0;
    int       m_tl = G;
    logic [1:0] m_prev = ST_START;

    task automatic push_ev(input int k, input int c, input int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        evq[k].push_back(e);
    endtask

    // Model: a level must be seen on the synchronised input for D straight edges to be accepted
    always @(posedge CLK) begin : model
        bit [1:0] raw;
        bit [1:0] rose_now;
        int       new_tl;
        bit       do_end;
        cyc    = cyc + 1;
        raw    = {btn_reset, btn_start};
        new_tl = m_tl;
        do_end = 1'b0;
        if (RST) begin
            m_s1   = '0;
            m_s2   = '0;
            m_db   = '0;
            m_lvl  = '0;
            m_rose = '0;
            m_run  = '{0, 0};
            m_prev = ST_START;
            m_n    = 0;
            new_tl = G;
        end else begin
            if (m_rose[1])
                push_ev(K_RESET, cyc, 1);
            else if (m_rose[0] && current_state != ST_PLAY)
                push_ev(K_START, cyc, 1);
            rose_now = '0;
            for (int i = 0; i < 2; i++) begin
                if (m_s2[i] == m_lvl[i]) begin
                    m_run[i] = m_run[i] + 1;
                end else begin
                    m_lvl[i] = m_s2[i];
                    m_run[i] = 1;
                end
                if (m_lvl[i] != m_db[i] && m_run[i] >= int'(D)) begin
                    m_db[i]     = m_lvl[i];
                    rose_now[i] = m_lvl[i];
                end
            end
            m_rose = rose_now;
            m_s2   = m_s1;
            m_s1   = raw;

            if (current_state == ST_PLAY && m_prev != ST_PLAY) begin
                m_n    = 0;
                new_tl = G;
            end else if (current_state == ST_PLAY) begin
                m_n    = m_n + 1;
                new_tl = (m_n / int'(T) >= int'(G)) ? 0 : int'(G) - m_n / int'(T);
                do_end = (m_n == int'(G * T));
            end else if (current_state == ST_START) begin
                new_tl = G;
            end
            m_prev = current_state;
        end
        if (do_end)
            push_ev(K_END, cyc, 1);
        if (new_tl != m_tl)
            push_ev(K_TL, cyc, new_tl);
        m_tl = new_tl;
    end

    task automatic check_evt(input int k, input string name, input bit fired, input int val);
        ev_t e;
        while (evq[k].size() > 0 && evq[k][0].cyc < cyc) begin
            e = evq[k].pop_front();
            checks++;
            errors++;
            $display("FAIL %s missing: nothing at cycle %0d, required value %0d", name, e.cyc, e.val);
        end
        if (fired) begin
            checks++;
            if (evq[k].size() == 0 || evq[k][0].cyc != cyc) begin
                errors++;
                $display("FAIL %s unexpected: got value %0d at cycle %0d, required no event", name, val, cyc);
            end else begin
                e = evq[k].pop_front();
                if (e.val != val) begin
                    errors++;
                    $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, val, e.val);
                end
            end
        end
    endtask

    always @(negedge CLK) begin : monitor
        check_evt(K_START, "start_game", start_game, 1);
        check_evt(K_RESET, "reset_game", reset_game, 1);
        check_evt(K_END, "end_game", end_game, 1);
        check_evt(K_TL, "time_left", time_left != last_tl, int'(time_left));
        last_tl = time_left;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        // Reset with start held: no pulse until a full debounce after release of reset
        btn_start = 1'b1;
        tick(2);
        chk("reset start_game", int'(start_game), 0);
        chk("reset reset_game", int'(reset_game), 0);
        chk("reset end_game", int'(end_game), 0);
        chk("reset time_left", int'(time_left), int'(G));
        RST = 1'b0;
        tick(20);
        btn_start = 1'b0;
        tick(10);

        // Short glitch
        btn_start = 1'b1;
        tick(3);
        btn_start = 1'b0;
        tick(10);

        // Start press during play, then full countdown and hold
        current_state = ST_PLAY;
        btn_start = 1'b1;
        tick(15);
        btn_start = 1'b0;
        tick(30);
        current_state = ST_END;
        tick(5);

        // Simultaneous start and reset presses
        btn_start = 1'b1;
        btn_reset = 1'b1;
        tick(12);
        btn_start = 1'b0;
        btn_reset = 1'b0;
        tick(8);

        // Re-entry from End with time_left at 0
        current_state = ST_PLAY;
        tick(35);
        current_state = ST_END;
        tick(3);

        // Leave play mid-round
        current_state = ST_PLAY;
        tick(12);
        current_state = ST_START;
        tick(5);

        // Reset in the middle of a debounce
        btn_start = 1'b1;
        tick(4);
        RST = 1'b1;
        btn_start = 1'b0;
        tick(1);
        RST = 1'b0;
        tick(12);

        // Randomised traffic
        for (int it = 0; it < 300; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                RST = 1'b1;
                tick(1);
                RST = 1'b0;
            end else if (r < 20) begin
                current_state = 2'($urandom_range(0, 3));
            end else if (r < 25) begin
                current_state = ST_PLAY;
                tick(35);
            end
            btn_start = 1'($urandom_range(0, 1));
            btn_reset = ($urandom_range(0, 3) == 0);
            tick(int'($urandom_range(1, 9)));
        end

        RST = 1'b0;
        btn_start = 1'b0;
        btn_reset = 1'b0;
        current_state = ST_END;
        tick(15);

        for (int k = 0; k < 4; k++) begin
            while (evq[k].size() > 0) begin
                ev_t e;
                e = evq[k].pop_front();
                checks++;
                errors++;
                $display("FAIL event kind %0d missing: nothing at cycle %0d, required value %0d", k, e.cyc, e.val);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
